// File: rtl/cirno9_memarb.sv
// cirno9_memarb: N-channel arbiter in front of the single-port SRAM.
// Fixed-priority or round-robin grant, combinational SRAM command path,
// and a latency-matched tag pipeline that routes read data back to its requester.
module cirno9_memarb #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          i_req_val,
  output logic [NCH-1:0]          o_req_rdy,
  input  logic [NCH*AW-1:0]       i_req_adr,
  input  logic [NCH*DW-1:0]       i_req_wdat,
  input  logic [NCH*(DW/8)-1:0]   i_req_wen,
  input  logic [NCH-1:0]          i_req_ren,
  output logic [NCH-1:0]          o_rsp_val,
  output logic [DW-1:0]           o_rsp_rdat,
  output logic [NCH-1:0]          o_err,
  output logic                    o_sram_ren,
  output logic [DW/8-1:0]         o_sram_wen,
  output logic [AW-1:0]           o_sram_adr,
  output logic [DW-1:0]           o_sram_wdat,
  input  logic                    i_sram_rdy,
  input  logic [DW-1:0]           i_sram_rdat
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]             ptr;
  logic [PW-1:0]             base_c;
  logic [PW-1:0]             gidx_c;
  logic [CW-1:0]             cand_c;
  logic                      found_c;
  logic                      xfer_c;
  logic                      sel_ren_c;
  logic [BW-1:0]             sel_wen_c;
  logic [NCH-1:0]            grant_c;
  logic [RD_LAT-1:0]         tag_vld;
  logic [RD_LAT-1:0][PW-1:0] tag_id;

  // Pick the first valid channel starting at the rotating base (channel 0 in fixed mode)
  always_comb begin
    base_c  = (RR_MODE != 0) ? ptr : '0;
    found_c = 1'b0;
    gidx_c  = '0;
    cand_c  = '0;
    grant_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand_c = CW'(base_c) + CW'(i);
      if (cand_c >= CW'(NCH)) cand_c = cand_c - CW'(NCH);
      if (!found_c && i_req_val[cand_c[PW-1:0]]) begin
        found_c = 1'b1;
        gidx_c  = cand_c[PW-1:0];
      end
    end
    // A lone channel is always granted so its ready tracks the SRAM alone
    if (NCH == 1) grant_c = '1;
    else if (found_c) grant_c[gidx_c] = 1'b1;
    o_req_rdy = grant_c & {NCH{i_sram_rdy}};
    xfer_c    = found_c & i_sram_rdy;
  end

  // Route the granted channel's command to the SRAM; strobes only fire on a transfer
  always_comb begin
    o_sram_adr  = i_req_adr[AW-1:0];
    o_sram_wdat = i_req_wdat[DW-1:0];
    sel_wen_c   = i_req_wen[BW-1:0];
    sel_ren_c   = i_req_ren[0];
    for (int unsigned k = 0; k < NCH; k++) begin
      if (gidx_c == PW'(k)) begin
        o_sram_adr  = i_req_adr[k*AW +: AW];
        o_sram_wdat = i_req_wdat[k*DW +: DW];
        sel_wen_c   = i_req_wen[k*BW +: BW];
        sel_ren_c   = i_req_ren[k];
      end
    end
    // Write wins when a request carries both read and write enables
    o_sram_wen = xfer_c ? sel_wen_c : '0;
    o_sram_ren = xfer_c & sel_ren_c & ~(|sel_wen_c);
    o_err      = (xfer_c & sel_ren_c & (|sel_wen_c)) ? grant_c : '0;
  end

  // Round-robin pointer moves past the channel that just transferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if ((RR_MODE != 0) && (NCH > 1) && xfer_c) begin
      ptr <= (gidx_c == PW'(NCH - 1)) ? '0 : gidx_c + PW'(1);
    end
  end

  // Tag shift register carrying the read requester's id alongside the SRAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= o_sram_ren;
      tag_id[0]  <= gidx_c;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Register the response: one-hot valid to the owner and the SRAM data beside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rsp_val  <= '0;
      o_rsp_rdat <= '0;
    end else begin
      o_rsp_val <= tag_vld[RD_LAT-1] ? (NCH'(1) << tag_id[RD_LAT-1]) : '0;
      if (tag_vld[RD_LAT-1]) o_rsp_rdat <= i_sram_rdat;
    end
  end

endmodule

// File: tb/tb_cirno9_memarb.sv
// Bench for cirno9_memarb: two instances side by side, round-robin with
// read latency 2 and fixed priority with read latency 4, sharing the SRAM ready.
module tb_cirno9_memarb;
  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int LAT0 = 2;
  localparam int LAT1 = 4;

  logic clk;
  logic rst;
  logic sram_rdy;
  logic [NCH-1:0]    req_val  [2];
  logic [NCH-1:0]    req_ren  [2];
  logic [NCH*AW-1:0] req_adr  [2];
  logic [NCH*DW-1:0] req_wdat [2];
  logic [NCH*BW-1:0] req_wen  [2];
  logic [NCH-1:0]    req_rdy  [2];
  logic [NCH-1:0]    rsp_val  [2];
  logic [DW-1:0]     rsp_rdat [2];
  logic [NCH-1:0]    err      [2];
  logic              sram_ren [2];
  logic [BW-1:0]     sram_wen [2];
  logic [AW-1:0]     sram_adr [2];
  logic [DW-1:0]     sram_wdat[2];
  logic [DW-1:0]     sram_rdat[2];

  int vectors;
  int miscompares;

  cirno9_memarb #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(LAT0), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .i_req_val(req_val[0]), .o_req_rdy(req_rdy[0]), .i_req_adr(req_adr[0]),
    .i_req_wdat(req_wdat[0]), .i_req_wen(req_wen[0]), .i_req_ren(req_ren[0]),
    .o_rsp_val(rsp_val[0]), .o_rsp_rdat(rsp_rdat[0]), .o_err(err[0]),
    .o_sram_ren(sram_ren[0]), .o_sram_wen(sram_wen[0]), .o_sram_adr(sram_adr[0]),
    .o_sram_wdat(sram_wdat[0]), .i_sram_rdy(sram_rdy), .i_sram_rdat(sram_rdat[0])
  );

  cirno9_memarb #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(LAT1), .RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst),
    .i_req_val(req_val[1]), .o_req_rdy(req_rdy[1]), .i_req_adr(req_adr[1]),
    .i_req_wdat(req_wdat[1]), .i_req_wen(req_wen[1]), .i_req_ren(req_ren[1]),
    .o_rsp_val(rsp_val[1]), .o_rsp_rdat(rsp_rdat[1]), .o_err(err[1]),
    .o_sram_ren(sram_ren[1]), .o_sram_wen(sram_wen[1]), .o_sram_adr(sram_adr[1]),
    .o_sram_wdat(sram_wdat[1]), .i_sram_rdy(sram_rdy), .i_sram_rdat(sram_rdat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int inst);
    return (inst == 0) ? LAT0 : LAT1;
  endfunction

  // Inputs change at the falling edge; SRAM read data is fresh noise unless overridden
  task automatic next_cyc();
    @(negedge clk);
    sram_rdat[0] = $urandom;
    sram_rdat[1] = $urandom;
  endtask

  task automatic clr_req();
    for (int i = 0; i < 2; i++) begin
      req_val[i] = '0; req_ren[i] = '0; req_adr[i] = '0; req_wdat[i] = '0; req_wen[i] = '0;
    end
  endtask

  task automatic set_req(input int inst, input int ch, input logic [AW-1:0] adr,
                         input logic [DW-1:0] wdat, input logic [BW-1:0] wen, input logic ren);
    req_val[inst][ch]            = 1'b1;
    req_ren[inst][ch]            = ren;
    req_adr[inst][ch*AW +: AW]   = adr;
    req_wdat[inst][ch*DW +: DW]  = wdat;
    req_wen[inst][ch*BW +: BW]   = wen;
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1;
    sram_rdy = 1'b1;
    clr_req();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      next_cyc();
      if (c == 1) rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++; if (rsp_val[i] !== 3'b000) begin miscompares++; $display("FAIL reset_rsp_val inst%0d got %b exp 000", i, rsp_val[i]); end
        vectors++; if (err[i] !== 3'b000) begin miscompares++; $display("FAIL reset_err inst%0d got %b exp 000", i, err[i]); end
        vectors++; if (req_rdy[i] !== 3'b000) begin miscompares++; $display("FAIL reset_rdy inst%0d got %b exp 000", i, req_rdy[i]); end
        vectors++; if (sram_ren[i] !== 1'b0 || sram_wen[i] !== 4'b0000) begin miscompares++; $display("FAIL reset_strobes inst%0d got ren %b wen %b exp 0 0000", i, sram_ren[i], sram_wen[i]); end
      end
    end
  endtask

  task automatic test_read_latency();
    logic [NCH-1:0] e_val;
    logic [DW-1:0]  e_dat;
    do_reset();
    next_cyc();
    for (int i = 0; i < 2; i++) set_req(i, 1, 32'h40, 32'h0, 4'b0000, 1'b1);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (req_rdy[i] !== 3'b010) begin miscompares++; $display("FAIL rdlat_rdy inst%0d got %b exp 010", i, req_rdy[i]); end
      vectors++; if (sram_ren[i] !== 1'b1 || sram_adr[i] !== 32'h40) begin miscompares++; $display("FAIL rdlat_cmd inst%0d got ren %b adr %h exp 1 00000040", i, sram_ren[i], sram_adr[i]); end
    end
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      clr_req();
      if (k == LAT0) sram_rdat[0] = 32'hDEADBEEF;
      if (k == LAT1) sram_rdat[1] = 32'hCAFEF00D;
      #1;
      for (int i = 0; i < 2; i++) begin
        e_val = (k == lat_of(i) + 1) ? 3'b010 : 3'b000;
        e_dat = (i == 0) ? 32'hDEADBEEF : 32'hCAFEF00D;
        vectors++; if (rsp_val[i] !== e_val) begin miscompares++; $display("FAIL rdlat_val inst%0d k%0d got %b exp %b", i, k, rsp_val[i], e_val); end
        if (e_val != 3'b000) begin
          vectors++; if (rsp_rdat[i] !== e_dat) begin miscompares++; $display("FAIL rdlat_dat inst%0d got %h exp %h", i, rsp_rdat[i], e_dat); end
        end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [NCH-1:0] e_rdy;
    logic [AW-1:0]  e_adr;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      for (int i = 0; i < 2; i++)
        for (int ch = 0; ch < NCH; ch++) set_req(i, ch, AW'(ch * 256 + k), 32'h0, 4'b0000, 1'b0);
      #1;
      for (int i = 0; i < 2; i++) begin
        e_rdy = (i == 0) ? (3'b001 << (k % 3)) : 3'b001;
        e_adr = (i == 0) ? AW'((k % 3) * 256 + k) : AW'(k);
        vectors++; if (req_rdy[i] !== e_rdy) begin miscompares++; $display("FAIL arb_grant inst%0d k%0d got %b exp %b", i, k, req_rdy[i], e_rdy); end
        vectors++; if (sram_adr[i] !== e_adr) begin miscompares++; $display("FAIL arb_adr inst%0d k%0d got %h exp %h", i, k, sram_adr[i], e_adr); end
        vectors++; if (sram_ren[i] !== 1'b0 || sram_wen[i] !== 4'b0000) begin miscompares++; $display("FAIL arb_noop_strobe inst%0d got ren %b wen %b exp 0 0000", i, sram_ren[i], sram_wen[i]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [NCH-1:0] e_rdy;
    do_reset();
    next_cyc();
    for (int i = 0; i < 2; i++) set_req(i, 0, 32'h0, 32'h0, 4'b0000, 1'b0);
    next_cyc();
    clr_req();
    sram_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 32'h10, 32'h0, 4'b0000, 1'b0);
      set_req(i, 2, 32'h88, 32'h5A5A0F0F, 4'b1010, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      if (k == 3) sram_rdy = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
        e_rdy = (k < 3) ? 3'b000 : ((i == 0) ? 3'b100 : 3'b001);
        vectors++; if (req_rdy[i] !== e_rdy) begin miscompares++; $display("FAIL stall_rdy inst%0d k%0d got %b exp %b", i, k, req_rdy[i], e_rdy); end
      end
      if (k < 3) begin
        vectors++; if (sram_wen[0] !== 4'b0000 || sram_ren[0] !== 1'b0) begin miscompares++; $display("FAIL stall_strobe k%0d got wen %b ren %b exp 0000 0", k, sram_wen[0], sram_ren[0]); end
      end else begin
        vectors++; if (sram_wen[0] !== 4'b1010 || sram_adr[0] !== 32'h88) begin miscompares++; $display("FAIL stall_release_cmd got wen %b adr %h exp 1010 00000088", sram_wen[0], sram_adr[0]); end
      end
    end
    next_cyc();
    clr_req();
  endtask

  task automatic test_write_err();
    do_reset();
    next_cyc();
    for (int i = 0; i < 2; i++) set_req(i, 0, 32'h80, 32'h12345678, 4'b0011, 1'b0);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (sram_wen[i] !== 4'b0011 || sram_ren[i] !== 1'b0) begin miscompares++; $display("FAIL wr_strobe inst%0d got wen %b ren %b exp 0011 0", i, sram_wen[i], sram_ren[i]); end
      vectors++; if (sram_wdat[i] !== 32'h12345678 || sram_adr[i] !== 32'h80) begin miscompares++; $display("FAIL wr_data inst%0d got %h@%h exp 12345678@00000080", i, sram_wdat[i], sram_adr[i]); end
      vectors++; if (err[i] !== 3'b000) begin miscompares++; $display("FAIL wr_err inst%0d got %b exp 000", i, err[i]); end
    end
    next_cyc();
    for (int i = 0; i < 2; i++) set_req(i, 0, 32'h84, 32'hA5A5A5A5, 4'b1111, 1'b1);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (sram_wen[i] !== 4'b1111 || sram_ren[i] !== 1'b0) begin miscompares++; $display("FAIL both_strobe inst%0d got wen %b ren %b exp 1111 0", i, sram_wen[i], sram_ren[i]); end
      vectors++; if (err[i] !== 3'b001) begin miscompares++; $display("FAIL both_err inst%0d got %b exp 001", i, err[i]); end
    end
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      clr_req();
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++; if (rsp_val[i] !== 3'b000 || err[i] !== 3'b000) begin miscompares++; $display("FAIL wr_no_rsp inst%0d k%0d got val %b err %b exp 000 000", i, k, rsp_val[i], err[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0]  drv [2][12];
    logic [NCH-1:0] e_val;
    int j;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      clr_req();
      if (k < 3) for (int i = 0; i < 2; i++) set_req(i, k, AW'(k * 4), 32'h0, 4'b0000, 1'b1);
      drv[0][k] = sram_rdat[0];
      drv[1][k] = sram_rdat[1];
      #1;
      for (int i = 0; i < 2; i++) begin
        j = k - lat_of(i) - 1;
        e_val = (j >= 0 && j < 3) ? (3'b001 << j) : 3'b000;
        vectors++; if (rsp_val[i] !== e_val) begin miscompares++; $display("FAIL b2b_val inst%0d k%0d got %b exp %b", i, k, rsp_val[i], e_val); end
        if (e_val != 3'b000) begin
          vectors++; if (rsp_rdat[i] !== drv[i][k-1]) begin miscompares++; $display("FAIL b2b_dat inst%0d k%0d got %h exp %h", i, k, rsp_rdat[i], drv[i][k-1]); end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    next_cyc();
    for (int i = 0; i < 2; i++) set_req(i, 1, 32'h44, 32'h0, 4'b0000, 1'b1);
    next_cyc();
    clr_req();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_cyc();
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++; if (rsp_val[i] !== 3'b000) begin miscompares++; $display("FAIL midrst_rsp inst%0d k%0d got %b exp 000", i, k, rsp_val[i]); end
      end
    end
    next_cyc();
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < NCH; ch++) set_req(i, ch, 32'h0, 32'h0, 4'b0000, 1'b0);
    #1;
    vectors++; if (req_rdy[0] !== 3'b001) begin miscompares++; $display("FAIL midrst_ptr got %b exp 001", req_rdy[0]); end
    next_cyc();
    clr_req();
  endtask

  // Random traffic against a queue-free model: modular search from a pointer plus a response calendar
  task automatic test_random();
    logic [NCH-1:0] sched [2][64];
    logic [NCH-1:0] drop  [2];
    logic [NCH-1:0] e_val, e_rdy, e_err;
    logic [DW-1:0]  prev_rdat [2];
    logic [BW-1:0]  wen;
    logic           ren;
    int mptr [2];
    int g, ch;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drop[i] = '0; mptr[i] = 0; prev_rdat[i] = '0;
      for (int s = 0; s < 64; s++) sched[i][s] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      next_cyc();
      sram_rdy = ($urandom % 4) != 0;
      for (int i = 0; i < 2; i++) begin
        req_val[i] = req_val[i] & ~drop[i];
        drop[i] = '0;
        for (int k = 0; k < NCH; k++) begin
          if (!req_val[i][k] && ($urandom % 2 == 1))
            set_req(i, k, $urandom, $urandom, ($urandom % 3 == 0) ? BW'($urandom) : 4'b0000, 1'($urandom));
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        e_val = sched[i][c % 64];
        sched[i][c % 64] = '0;
        g = -1;
        for (int n = 0; n < NCH; n++) begin
          ch = (mptr[i] + n) % NCH;
          if (g < 0 && req_val[i][ch]) g = ch;
        end
        e_rdy = (g >= 0 && sram_rdy) ? (3'b001 << g) : 3'b000;
        vectors++; if (req_rdy[i] !== e_rdy) begin miscompares++; $display("FAIL rnd_rdy inst%0d c%0d got %b exp %b", i, c, req_rdy[i], e_rdy); end
        vectors++; if (rsp_val[i] !== e_val) begin miscompares++; $display("FAIL rnd_rsp_val inst%0d c%0d got %b exp %b", i, c, rsp_val[i], e_val); end
        if (e_val != 3'b000) begin
          vectors++; if (rsp_rdat[i] !== prev_rdat[i]) begin miscompares++; $display("FAIL rnd_rsp_dat inst%0d c%0d got %h exp %h", i, c, rsp_rdat[i], prev_rdat[i]); end
        end
        if (e_rdy != 3'b000) begin
          wen = req_wen[i][g*BW +: BW];
          ren = req_ren[i][g];
          e_err = (ren && wen != 0) ? (3'b001 << g) : 3'b000;
          vectors++; if (sram_wen[i] !== wen || sram_ren[i] !== (ren && wen == 0)) begin miscompares++; $display("FAIL rnd_strobe inst%0d c%0d got wen %b ren %b exp %b %b", i, c, sram_wen[i], sram_ren[i], wen, (ren && wen == 0)); end
          vectors++; if (sram_adr[i] !== req_adr[i][g*AW +: AW] || sram_wdat[i] !== req_wdat[i][g*DW +: DW]) begin miscompares++; $display("FAIL rnd_cmd inst%0d c%0d got %h/%h exp %h/%h", i, c, sram_adr[i], sram_wdat[i], req_adr[i][g*AW +: AW], req_wdat[i][g*DW +: DW]); end
          vectors++; if (err[i] !== e_err) begin miscompares++; $display("FAIL rnd_err inst%0d c%0d got %b exp %b", i, c, err[i], e_err); end
          if (ren && wen == 0) sched[i][(c + lat_of(i) + 1) % 64] = sched[i][(c + lat_of(i) + 1) % 64] | (3'b001 << g);
          if (i == 0) mptr[i] = (g + 1) % NCH;
          drop[i] = 3'b001 << g;
        end else begin
          vectors++; if (sram_wen[i] !== 4'b0000 || sram_ren[i] !== 1'b0 || err[i] !== 3'b000) begin miscompares++; $display("FAIL rnd_idle inst%0d c%0d got wen %b ren %b err %b exp 0000 0 000", i, c, sram_wen[i], sram_ren[i], err[i]); end
        end
        prev_rdat[i] = sram_rdat[i];
      end
    end
    next_cyc();
    clr_req();
    sram_rdy = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sram_rdy    = 1'b1;
    sram_rdat[0] = '0;
    sram_rdat[1] = '0;
    clr_req();
    test_reset();
    test_read_latency();
    test_arbitration();
    test_stall();
    test_write_err();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
